fpga_cfg_loader: RTL and testbench
==================================

// Module: fpga_cfg_loader
// PURPOSE
//  Synthesizable configuration sequencer for the fpga fabric top. Accepts a bitstream as a
//  stream of frame words over a valid/ready handshake. Drives the fabric's configs_in bus
//  and one-hot configs_en strobes frame by frame, then waits a settle window, releases
//  ff_en and raises rdy. Sits between the off-chip/host loader and the fpga instance.
// PARAMETERS
//  WORD_W      320  width of one configuration frame word (fabric configs_in width)
//  NUM_FRAMES  172  number of frames / configs_en bits
//  SETTLE_CYC  10   clock cycles between last strobe and ff_en release (>=1)
//  CNT_W  $clog2(NUM_FRAMES+1)  frame counter width (localparam)
// PORTS
//  clock       in   1          single system clock, rising edge
//  rst         in   1          asynchronous, active-high reset
//  start       in   1          1-cycle pulse: begin a load (honoured in IDLE/DONE only)
//  cfg_valid   in   1          cfg_data holds a valid frame word
//  cfg_data    in   WORD_W     frame word, frame 0 first
//  cfg_ready   out  1          loader accepts cfg_data this cycle
//  configs_in  out  WORD_W     registered frame word to fabric
//  configs_en  out  NUM_FRAMES one-hot frame write strobe to fabric
//  ff_en       out  1          fabric flip-flop enable
//  rdy         out  1          configuration complete and fabric running
//  busy        out  1          load in progress (state not IDLE/DONE)
//  frame_cnt   out  CNT_W      frames written so far
//  err         out  1          sticky load error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; configs_in=0, configs_en=0, ff_en=0, rdy=0, busy=0, cfg_ready=0,
//   frame_cnt=0, err=0. Reset mid-load aborts immediately; fabric outputs drop same instant.
//  States: IDLE -> LOAD -> STROBE -> (LOAD | SETTLE) -> DONE.
//  IDLE: start=1 -> LOAD, frame_cnt<=0, err<=0, ff_en<=0, rdy<=0.
//  LOAD: cfg_ready=1 (combinational from state). Transfer on cfg_valid&&cfg_ready:
//   configs_in<=cfg_data, -> STROBE. No transfer: stay, configs_in holds.
//  STROBE: exactly one cycle; configs_en = 1<<frame_cnt (registered, all other cycles 0);
//   configs_in stable the cycle before and during strobe. frame_cnt<=frame_cnt+1.
//   If frame_cnt==NUM_FRAMES-1 -> SETTLE (settle counter<=0) else -> LOAD.
//  Throughput: max one frame per 2 cycles; cfg_ready low during STROBE.
//  SETTLE: count SETTLE_CYC cycles, then ff_en<=1 -> DONE.
//  DONE: rdy<=1 one cycle after ff_en. ff_en/rdy hold until rst or new start.
//  start while busy: ignored. start in DONE: reload (ff_en,rdy drop next cycle, -> LOAD).
//  cfg_valid outside LOAD: ignored, no data consumed. frame_cnt saturates at NUM_FRAMES.
//  configs_en never has more than one bit set; frame_cnt never wraps.
// CONFIGURATION
//  Macro FPGA_CFG_LOADER_CHECK_EN:
//   Defined: after frame NUM_FRAMES-1, LOAD accepts one extra checksum word = XOR of all
//    frame words; no strobe for it. Match -> SETTLE. Mismatch -> err<=1, -> IDLE with
//    ff_en=0, rdy=0 (fabric never enabled).
//   Undefined: no checksum word, no XOR register; err tied 0; STROBE of last frame -> SETTLE.
// TESTING
//  1 rst high with toggling inputs -> all outputs 0; deassert, no start -> stay IDLE, cfg_ready=0.
//  2 start, NUM_FRAMES words back-to-back, word k = k -> configs_en bit k high 1 cycle while
//    configs_in=k; ff_en high SETTLE_CYC cycles after last strobe; rdy 1 cycle later; frame_cnt=172.
//  3 random cfg_valid gaps (30% idle) -> same frame/strobe sequence as 2, no dropped/duplicate words.
//  4 rst asserted after frame 50 strobe -> configs_en=0, ff_en=0, busy=0 same cycle; restart loads
//    all 172 frames from frame 0.
//  5 start pulse while busy, start in DONE -> first ignored; second drops rdy/ff_en and reloads.
//  6 (CHECK_EN) correct checksum -> rdy=1; checksum bit 0 flipped -> err=1, ff_en/rdy stay 0, IDLE.

Source files
------------

// File: rtl/fpga_cfg_loader_if.sv
// rtl/fpga_cfg_loader_if.sv - bitstream stream, control and fabric configuration bus for fpga_cfg_loader
interface fpga_cfg_loader_if #(
    parameter int WORD_W     = 320,
    parameter int NUM_FRAMES = 172,
    parameter int CNT_W      = $clog2(NUM_FRAMES + 1)
);
    // Host side: load request and frame word stream
    logic                  start;
    logic                  cfg_valid;
    logic [WORD_W-1:0]     cfg_data;
    logic                  cfg_ready;

    // Fabric side: frame data, one-hot write strobes, run enable
    logic [WORD_W-1:0]     configs_in;
    logic [NUM_FRAMES-1:0] configs_en;
    logic                  ff_en;

    // Status
    logic                  rdy;
    logic                  busy;
    logic [CNT_W-1:0]      frame_cnt;
    logic                  err;

    modport master (
        output start, cfg_valid, cfg_data,
        input  cfg_ready, configs_in, configs_en, ff_en, rdy, busy, frame_cnt, err
    );

    modport slave (
        input  start, cfg_valid, cfg_data,
        output cfg_ready, configs_in, configs_en, ff_en, rdy, busy, frame_cnt, err
    );
endinterface

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - frame-by-frame fabric configuration sequencer; optional checksum word via FPGA_CFG_LOADER_CHECK_EN
module fpga_cfg_loader #(
    parameter int WORD_W     = 320,
    parameter int NUM_FRAMES = 172,
    parameter int SETTLE_CYC = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fpga_cfg_loader_if.slave    bus_s
);
    localparam int CNT_W = $clog2(NUM_FRAMES + 1);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CNT_W-1:0]      LAST_IDX   = CNT_W'(NUM_FRAMES - 1);
    localparam logic [CNT_W-1:0]      CNT_SAT    = CNT_W'(NUM_FRAMES);
    localparam logic [SET_W-1:0]      SETTLE_END = SET_W'(SETTLE_CYC - 1);
    localparam logic [NUM_FRAMES-1:0] EN_ONE     = NUM_FRAMES'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STROBE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     configs_in_q, configs_in_d;
    logic [NUM_FRAMES-1:0] configs_en_q, configs_en_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [SET_W-1:0]      settle_q, settle_d;
    logic                  ff_en_q, ff_en_d;
    logic                  rdy_q, rdy_d;
`ifdef FPGA_CFG_LOADER_CHECK_EN
    logic                  err_q, err_d;
    logic [WORD_W-1:0]     xor_q, xor_d;
`endif

    // Ready is purely a function of state so the host sees it without a cycle of lag
    logic cfg_ready;
    logic xfer;
    assign cfg_ready = (state_q == ST_LOAD);
    assign xfer      = cfg_ready && bus_s.cfg_valid;

    // State and output registers; async reset drops every fabric-facing output at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            configs_in_q <= '0;
            configs_en_q <= '0;
            frame_cnt_q  <= '0;
            settle_q     <= '0;
            ff_en_q      <= 1'b0;
            rdy_q        <= 1'b0;
`ifdef FPGA_CFG_LOADER_CHECK_EN
            err_q        <= 1'b0;
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            configs_in_q <= configs_in_d;
            configs_en_q <= configs_en_d;
            frame_cnt_q  <= frame_cnt_d;
            settle_q     <= settle_d;
            ff_en_q      <= ff_en_d;
            rdy_q        <= rdy_d;
`ifdef FPGA_CFG_LOADER_CHECK_EN
            err_q        <= err_d;
            xor_q        <= xor_d;
`endif
        end
    end

    // Sequencer: take a word in LOAD, fire its strobe from STROBE, then settle and release the fabric
    always_comb begin
        state_d      = state_q;
        configs_in_d = configs_in_q;
        configs_en_d = '0;
        frame_cnt_d  = frame_cnt_q;
        settle_d     = settle_q;
        ff_en_d      = ff_en_q;
        rdy_d        = rdy_q;
`ifdef FPGA_CFG_LOADER_CHECK_EN
        err_d        = err_q;
        xor_d        = xor_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus_s.start) begin
                    state_d     = ST_LOAD;
                    frame_cnt_d = '0;
                    ff_en_d     = 1'b0;
                    rdy_d       = 1'b0;
`ifdef FPGA_CFG_LOADER_CHECK_EN
                    err_d       = 1'b0;
                    xor_d       = '0;
`endif
                end
            end

            ST_LOAD: begin
                if (xfer) begin
`ifdef FPGA_CFG_LOADER_CHECK_EN
                    // With every frame written, the next word is the checksum, never a frame
                    if (frame_cnt_q == CNT_SAT) begin
                        if (bus_s.cfg_data == xor_q) begin
                            state_d  = ST_SETTLE;
                            settle_d = '0;
                        end else begin
                            state_d  = ST_IDLE;
                            err_d    = 1'b1;
                        end
                    end else begin
                        configs_in_d = bus_s.cfg_data;
                        xor_d        = xor_q ^ bus_s.cfg_data;
                        state_d      = ST_STROBE;
                    end
`else
                    configs_in_d = bus_s.cfg_data;
                    state_d      = ST_STROBE;
`endif
                end
            end

            ST_STROBE: begin
                // Strobe is registered, so it lands the cycle after STROBE while configs_in is still held
                configs_en_d = EN_ONE << frame_cnt_q;
                if (frame_cnt_q != CNT_SAT) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
                if (frame_cnt_q == LAST_IDX) begin
`ifdef FPGA_CFG_LOADER_CHECK_EN
                    state_d  = ST_LOAD;
`else
                    state_d  = ST_SETTLE;
                    settle_d = '0;
`endif
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_SETTLE: begin
                if (settle_q == SETTLE_END) begin
                    ff_en_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            ST_DONE: begin
                // rdy follows ff_en by one cycle; a new start tears both down and reloads
                if (bus_s.start) begin
                    state_d     = ST_LOAD;
                    frame_cnt_d = '0;
                    ff_en_d     = 1'b0;
                    rdy_d       = 1'b0;
`ifdef FPGA_CFG_LOADER_CHECK_EN
                    err_d       = 1'b0;
                    xor_d       = '0;
`endif
                end else begin
                    rdy_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_s.cfg_ready  = cfg_ready;
    assign bus_s.configs_in = configs_in_q;
    assign bus_s.configs_en = configs_en_q;
    assign bus_s.ff_en      = ff_en_q;
    assign bus_s.rdy        = rdy_q;
    assign bus_s.busy       = (state_q == ST_LOAD) || (state_q == ST_STROBE) || (state_q == ST_SETTLE);
    assign bus_s.frame_cnt  = frame_cnt_q;
`ifdef FPGA_CFG_LOADER_CHECK_EN
    assign bus_s.err        = err_q;
`else
    assign bus_s.err        = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - scoreboard bench for fpga_cfg_loader
module tb_fpga_cfg_loader;
    localparam int WORD_W     = 320;
    localparam int NUM_FRAMES = 172;
    localparam int SETTLE_CYC = 10;
    localparam int CNT_W      = $clog2(NUM_FRAMES + 1);

    typedef logic [WORD_W-1:0] word_t;
    typedef struct {
        int    idx;
        word_t data;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpga_cfg_loader_if #(.WORD_W(WORD_W), .NUM_FRAMES(NUM_FRAMES)) bus_if();

    fpga_cfg_loader #(
        .WORD_W(WORD_W), .NUM_FRAMES(NUM_FRAMES), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus_s(bus_if.slave)
    );

    frame_t exp_q[$];
    int     exp_done_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_strobe_cyc = 0;
    int     ff_rise_cyc = 0;
    word_t  xor_acc;

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic word_t onehot(input int idx);
        logic [NUM_FRAMES-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return WORD_W'(r);
    endfunction

    function automatic word_t mk_word(input int k, input int mode);
        logic [31:0] v;
        v = 32'(k) ^ 32'h5A5A_0000;
        if (mode == 0) return WORD_W'(k);
        return WORD_W'({10{v}});
    endfunction

    // Monitor: pops the scoreboard whenever the fabric sees a strobe or enable edge
    initial begin
        frame_t e;
        int     lat;
        logic   en_prev, ff_prev, rdy_prev;
        en_prev = 1'b0; ff_prev = 1'b0; rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                en_prev = 1'b0; ff_prev = 1'b0; rdy_prev = 1'b0;
            end else begin
                if (bus_if.configs_en != '0) begin
                    if (en_prev) check("strobe_back_to_back", WORD_W'(1), WORD_W'(0));
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", WORD_W'(bus_if.configs_en), WORD_W'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("strobe_en_%0d", e.idx), WORD_W'(bus_if.configs_en), onehot(e.idx));
                        check($sformatf("strobe_data_%0d", e.idx), bus_if.configs_in, e.data);
                        check($sformatf("strobe_cnt_%0d", e.idx), WORD_W'(bus_if.frame_cnt), WORD_W'(e.idx + 1));
                    end
                    last_strobe_cyc = cyc;
                end
                en_prev = (bus_if.configs_en != '0);
                if (bus_if.ff_en && !ff_prev) begin
                    if (exp_done_q.size() == 0) begin
                        check("unexpected_ff_en", WORD_W'(1), WORD_W'(0));
                    end else begin
                        lat = exp_done_q.pop_front();
                        check("ff_en_latency", WORD_W'(cyc - last_strobe_cyc), WORD_W'(lat));
                        check("frames_pending_at_ff_en", WORD_W'(exp_q.size()), WORD_W'(0));
                    end
                    ff_rise_cyc = cyc;
                end
                if (bus_if.rdy && !rdy_prev) begin
                    check("rdy_after_ff_en", WORD_W'(cyc - ff_rise_cyc), WORD_W'(1));
                end
                ff_prev  = bus_if.ff_en;
                rdy_prev = bus_if.rdy;
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_configs_in"}, bus_if.configs_in, WORD_W'(0));
        check({tag, "_configs_en"}, WORD_W'(bus_if.configs_en), WORD_W'(0));
        check({tag, "_ff_en"}, WORD_W'(bus_if.ff_en), WORD_W'(0));
        check({tag, "_rdy"}, WORD_W'(bus_if.rdy), WORD_W'(0));
        check({tag, "_busy"}, WORD_W'(bus_if.busy), WORD_W'(0));
        check({tag, "_cfg_ready"}, WORD_W'(bus_if.cfg_ready), WORD_W'(0));
        check({tag, "_frame_cnt"}, WORD_W'(bus_if.frame_cnt), WORD_W'(0));
        check({tag, "_err"}, WORD_W'(bus_if.err), WORD_W'(0));
    endtask

    task automatic send_word(input word_t d, input int gap);
        logic r, got;
        got = 1'b0;
        if (gap > 0) begin
            bus_if.cfg_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        bus_if.cfg_valid = 1'b1;
        bus_if.cfg_data  = d;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            r = bus_if.cfg_ready;
            @(posedge clk);
            #1;
            got = r;
        end
        bus_if.cfg_valid = 1'b0;
        if (!got) check("handshake_timeout", WORD_W'(0), WORD_W'(1));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    task automatic begin_load();
        xor_acc = '0;
        pulse_start();
    endtask

    task automatic load_frames(input int lo, input int hi, input int mode, input int gap_pct);
        word_t d;
        int    gap;
        for (int k = lo; k <= hi; k++) begin
            d = mk_word(k, mode);
            xor_acc ^= d;
            exp_q.push_back('{idx: k, data: d});
            gap = (int'($urandom_range(99)) < gap_pct) ? int'($urandom_range(3, 1)) : 0;
            send_word(d, gap);
        end
    endtask

    task automatic finish_load();
`ifdef FPGA_CFG_LOADER_CHECK_EN
        exp_done_q.push_back(SETTLE_CYC + 1);
        send_word(xor_acc, 0);
`else
        exp_done_q.push_back(SETTLE_CYC);
`endif
    endtask

    task automatic wait_rdy(input string tag);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = bus_if.rdy;
        end
        check({tag, "_rdy_seen"}, WORD_W'(seen), WORD_W'(1));
        check({tag, "_frame_cnt"}, WORD_W'(bus_if.frame_cnt), WORD_W'(NUM_FRAMES));
        check({tag, "_ff_en"}, WORD_W'(bus_if.ff_en), WORD_W'(1));
        check({tag, "_busy"}, WORD_W'(bus_if.busy), WORD_W'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.start     = 1'b0;
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_data  = '0;
        xor_acc          = '0;

        // 1: reset held with inputs toggling, then idle with stray cfg_valid
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus_if.start     = i[0];
            bus_if.cfg_valid = ~i[0];
            bus_if.cfg_data  = WORD_W'(32'h1357_9BDF * (i + 1));
            @(negedge clk);
            check_idle($sformatf("reset_%0d", i));
        end
        @(posedge clk); #1;
        bus_if.start     = 1'b0;
        bus_if.cfg_valid = 1'b1;
        rst              = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_idle("idle_no_start");
        @(posedge clk); #1;
        bus_if.cfg_valid = 1'b0;

        // 2: back-to-back frames, word k = k
        begin_load();
        load_frames(0, NUM_FRAMES - 1, 0, 0);
        finish_load();
        wait_rdy("b2b");

        // 3: ~30% valid gaps, patterned words
        begin_load();
        load_frames(0, NUM_FRAMES - 1, 1, 30);
        finish_load();
        wait_rdy("gaps");

        // 4: reset during frame 50 strobe, then a full reload
        begin_load();
        load_frames(0, 50, 0, 0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("abort_pre_en", WORD_W'(bus_if.configs_en), onehot(50));
        rst = 1'b1;
        #1;
        check("abort_configs_en", WORD_W'(bus_if.configs_en), WORD_W'(0));
        check("abort_ff_en", WORD_W'(bus_if.ff_en), WORD_W'(0));
        check("abort_busy", WORD_W'(bus_if.busy), WORD_W'(0));
        check("abort_frame_cnt", WORD_W'(bus_if.frame_cnt), WORD_W'(0));
        check("abort_configs_in", bus_if.configs_in, WORD_W'(0));
        check("abort_queue_drained", WORD_W'(exp_q.size()), WORD_W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        begin_load();
        load_frames(0, NUM_FRAMES - 1, 0, 0);
        finish_load();
        wait_rdy("reload");

        // 5: start while busy is ignored; start in DONE reloads
        begin_load();
        load_frames(0, 9, 0, 0);
        pulse_start();
        check("busy_start_cnt", WORD_W'(bus_if.frame_cnt), WORD_W'(10));
        load_frames(10, NUM_FRAMES - 1, 0, 0);
        finish_load();
        wait_rdy("busy_start");
        pulse_start();
        xor_acc = '0;
        check("done_start_ff_en", WORD_W'(bus_if.ff_en), WORD_W'(0));
        check("done_start_rdy", WORD_W'(bus_if.rdy), WORD_W'(0));
        check("done_start_busy", WORD_W'(bus_if.busy), WORD_W'(1));
        check("done_start_cnt", WORD_W'(bus_if.frame_cnt), WORD_W'(0));
        load_frames(0, NUM_FRAMES - 1, 1, 0);
        finish_load();
        wait_rdy("done_start");

`ifdef FPGA_CFG_LOADER_CHECK_EN
        // 6: corrupted checksum leaves the fabric disabled
        begin_load();
        load_frames(0, NUM_FRAMES - 1, 0, 0);
        send_word(xor_acc ^ WORD_W'(1), 0);
        repeat (SETTLE_CYC + 5) @(negedge clk);
        check("bad_sum_err", WORD_W'(bus_if.err), WORD_W'(1));
        check("bad_sum_ff_en", WORD_W'(bus_if.ff_en), WORD_W'(0));
        check("bad_sum_rdy", WORD_W'(bus_if.rdy), WORD_W'(0));
        check("bad_sum_busy", WORD_W'(bus_if.busy), WORD_W'(0));
        check("bad_sum_cfg_ready", WORD_W'(bus_if.cfg_ready), WORD_W'(0));
`endif

        repeat (20) @(negedge clk);
        check("final_frames_left", WORD_W'(exp_q.size()), WORD_W'(0));
        check("final_done_left", WORD_W'(exp_done_q.size()), WORD_W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
